// File: rtl/regfile_dump_reader_pkg.sv
// Shared widths and FSM state encoding for the register-file dump reader.
// The width defaults are common with the register file and datapath.
package regfile_dump_reader_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range through one combinational read port and
// streams each register out as a valid/ready beat, holding freeze while active.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              freeze,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] last_q;
    logic              accept;
    logic              handshake;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        handshake  = out_valid && out_ready;
        freeze     = (state == READ) || (state == SEND);
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (first_addr <= last_addr) begin
                        accept     = 1'b1;
                        state_next = READ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            READ: state_next = SEND;
            SEND: begin
                if (handshake) begin
                    state_next = out_last ? DONE : READ;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort wins over every transition; in IDLE it is simply a no-op.
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_q  <= last_addr;
                        rd_addr <= first_addr;
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= rd_addr;
                    out_last  <= (rd_addr == last_q);
                    out_valid <= 1'b1;
                end
                SEND: begin
                    // Stopping at last_q keeps rd_addr from wrapping at the top address.
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (!out_last) begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (abort) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural register file on the read port.
module tb_regfile_dump_reader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          freeze;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rf [32];
    int total = 0;
    int bad   = 0;

    assign rd_data = rf[rd_addr];

    regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .freeze     (freeze),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chka({tag, "_rd_addr"}, rd_addr, '0);
        chk1({tag, "_freeze"}, freeze, 1'b0);
        chk1({tag, "_valid"}, out_valid, 1'b0);
        chkd({tag, "_data"}, out_data, '0);
        chka({tag, "_index"}, out_index, '0);
        chk1({tag, "_last"}, out_last, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    task automatic accept_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA5A5_0000 + 32'(i);
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        first_addr = '0; last_addr = '0;
        tick(); tick();
        chk_reset_outputs("rst0");
        rst = 1'b0;

        // 1) full range 0..31, ready tied high
        accept_start(5'd0, 5'd31);
        chk1("t1_freeze_read", freeze, 1'b1);
        chk1("t1_busy_read", busy, 1'b1);
        chk1("t1_novalid_read", out_valid, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk1("t1_valid", out_valid, 1'b1);
            chka("t1_index", out_index, 5'(i));
            chkd("t1_data", out_data, 32'hA5A5_0000 + 32'(i));
            chk1("t1_last", out_last, (i == 31));
            chk1("t1_nodone", done, 1'b0);
            tick();
            chk1("t1_valid_cleared", out_valid, 1'b0);
        end
        chk1("t1_done", done, 1'b1);
        chk1("t1_freeze_done", freeze, 1'b0);
        tick();
        chk1("t1_done_pulse", done, 1'b0);
        chk1("t1_idle", busy, 1'b0);

        // 2) single register 5
        accept_start(5'd5, 5'd5);
        chk1("t2_freeze_c1", freeze, 1'b1);
        tick();
        chk1("t2_freeze_c2", freeze, 1'b1);
        chk1("t2_valid", out_valid, 1'b1);
        chka("t2_index", out_index, 5'd5);
        chkd("t2_data", out_data, 32'hA5A5_0005);
        chk1("t2_last", out_last, 1'b1);
        tick();
        chk1("t2_freeze_off", freeze, 1'b0);
        chk1("t2_done", done, 1'b1);
        tick();
        chk1("t2_idle", busy, 1'b0);

        // 3) empty range 9..3
        accept_start(5'd9, 5'd3);
        chk1("t3_done", done, 1'b1);
        chk1("t3_freeze", freeze, 1'b0);
        chk1("t3_novalid", out_valid, 1'b0);
        tick();
        chk1("t3_done_pulse", done, 1'b0);
        chk1("t3_idle", busy, 1'b0);
        chk1("t3_novalid2", out_valid, 1'b0);

        // 4) range 0..3 with backpressure for 4 cycles per beat
        out_ready = 1'b0;
        accept_start(5'd0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                chk1("t4_valid_hold", out_valid, 1'b1);
                chka("t4_index_hold", out_index, 5'(i));
                chkd("t4_data_hold", out_data, 32'hA5A5_0000 + 32'(i));
                chk1("t4_last_hold", out_last, (i == 3));
                if (k < 3) tick();
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk1("t4_valid_cleared", out_valid, 1'b0);
        end
        chk1("t4_done", done, 1'b1);
        tick();
        chk1("t4_idle", busy, 1'b0);

        // 5) abort during the third beat of 0..31
        out_ready = 1'b1;
        accept_start(5'd0, 5'd31);
        tick(); tick(); tick(); tick();
        out_ready = 1'b0;
        tick();
        chka("t5_third_beat", out_index, 5'd2);
        chk1("t5_third_valid", out_valid, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("t5_valid_drop", out_valid, 1'b0);
        chk1("t5_no_done", done, 1'b0);
        chk1("t5_idle", busy, 1'b0);
        chk1("t5_freeze_drop", freeze, 1'b0);
        tick();
        chk1("t5_no_done_later", done, 1'b0);
        // abort together with start in IDLE: start must be ignored
        abort = 1'b1;
        accept_start(5'd0, 5'd1);
        abort = 1'b0;
        chk1("t5_abort_wins", busy, 1'b0);
        out_ready = 1'b1;
        accept_start(5'd4, 5'd31);
        chk1("t5_restart_busy", busy, 1'b1);
        tick();
        chka("t5_restart_index", out_index, 5'd4);
        chk1("t5_restart_valid", out_valid, 1'b1);

        // 6) reset mid-dump, then start while busy is ignored
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("t6_rst");
        accept_start(5'd10, 5'd12);
        first_addr = 5'd20; last_addr = 5'd20; start = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            tick();
            chk1("t6_valid", out_valid, 1'b1);
            chka("t6_index", out_index, 5'(i));
            chkd("t6_data", out_data, 32'hA5A5_0000 + 32'(i));
            chk1("t6_last", out_last, (i == 12));
            tick();
        end
        start = 1'b0;
        chk1("t6_done", done, 1'b1);
        tick();
        chk1("t6_idle", busy, 1'b0);
        chk1("t6_novalid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
